instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 13'h0000, is the PC value loaded on reset and on each start.
REQ-002 Parameter AW, default 13, is the instruction address width; instruction width is fixed at 16.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; begins fetching from RESET_PC when block is idle or halted.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  AW  instruction memory read address, equals pc.
REQ-008 imem_rdata  input  16  instruction word, sampled when imem_ack=1.
REQ-009 imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-010 ir_valid  output  1  opcode/operand hold a valid instruction for the execute stage.
REQ-011 opcode  output  3  instruction register bits [15:13].
REQ-012 operand  output  13  instruction register bits [12:0]; direct address or immediate.
REQ-013 exec_done  input  1  one-cycle pulse from execute stage; current instruction retired.
REQ-014 pc_src  input  1  controller jump select, sampled with exec_done.
REQ-015 halt  input  1  controller halt flag, sampled with exec_done.
REQ-016 pc  output  AW  current program counter.
REQ-017 halted  output  1  block is in HALTED state.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ISSUE and HALTED, with state and pc registered.
REQ-019 In IDLE, start=1 SHALL set pc to RESET_PC and move to FETCH on the next edge.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in all other states.
REQ-021 In FETCH with imem_ack=1, the block SHALL load IR from imem_rdata, set pc to pc+1 modulo 2^AW, and move to ISSUE.
REQ-022 FETCH SHALL wait any number of cycles for imem_ack without timeout.
REQ-023 In ISSUE, ir_valid SHALL be 1 and IR SHALL be held constant until exec_done=1.
REQ-024 In ISSUE with exec_done=1 and halt=1, the block SHALL move to HALTED with pc unchanged; halt SHALL take priority over pc_src.
REQ-025 In ISSUE with exec_done=1, halt=0 and pc_src=1, the block SHALL set pc to operand and move to FETCH.
REQ-026 In ISSUE with exec_done=1, halt=0 and pc_src=0, the block SHALL move to FETCH with pc unchanged.
REQ-027 In HALTED, halted SHALL be 1; start=1 SHALL set pc to RESET_PC, clear halted on the next edge, and move to FETCH.
REQ-028 Instruction-issue latency SHALL be one cycle: ir_valid rises on the edge after the cycle in which imem_ack=1.
REQ-029 The minimum instruction period SHALL be 2 cycles: FETCH with immediate ack, then ISSUE with immediate exec_done.
REQ-030 imem_ack outside FETCH and exec_done outside ISSUE SHALL be ignored.
REQ-031 start SHALL be ignored in FETCH and ISSUE.
REQ-032 The pc increment SHALL wrap from 13'h1FFF to 13'h0000 with no flag.
REQ-033 ir_valid SHALL be 0 in IDLE, FETCH and HALTED; opcode and operand SHALL hold the last IR value in those states.

Reset
REQ-034 While rst_n=0, outputs SHALL be: state IDLE, pc=RESET_PC, IR=16'h0000, imem_req=0, ir_valid=0, halted=0.
REQ-035 Reset asserted mid-fetch or mid-issue SHALL abort immediately; a pending imem_ack arriving after reset SHALL be ignored.
REQ-036 After rst_n deasserts, the block SHALL stay in IDLE until start=1 is sampled on a clock edge.

Verification
REQ-037 Reset, then start=1, imem_ack=1 with rdata=16'h4005 -> imem_addr=0, then ir_valid=1, opcode=3'b010, operand=13'h0005, pc=1.
REQ-038 In ISSUE with operand=13'h0123, exec_done=1 and pc_src=1 -> next FETCH has imem_addr=13'h0123.
REQ-039 exec_done=1 with halt=1 and pc_src=1 -> halted=1, pc unchanged, imem_req=0; then start=1 -> FETCH at addr 0, halted=0.
REQ-040 pc=13'h1FFF, then ack -> pc=13'h0000; imem_ack held off 5 cycles -> imem_req stays 1 and ir_valid stays 0 until ack.
REQ-041 rst_n low during FETCH with ack in the following cycle -> IDLE, ir_valid=0, IR=0, ack ignored.
REQ-042 Spurious exec_done in FETCH and imem_ack in ISSUE -> no state, pc or IR change.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM: PC, instruction register and memory read handshake
module instr_fetch #(
    parameter int            AW       = 13,
    parameter logic [AW-1:0] RESET_PC = 13'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    input  logic          imem_ack,
    output logic          ir_valid,
    output logic [2:0]    opcode,
    output logic [12:0]   operand,
    input  logic          exec_done,
    input  logic          pc_src,
    input  logic          halt,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] ir;

    assign imem_addr = pc;
    assign opcode    = ir[15:13];
    assign operand   = ir[12:0];

    // imem_req, ir_valid and halted are registered one-hot views of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc       <= RESET_PC;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        pc       <= pc + AW'(1);
                        state    <= ISSUE;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        ir_valid <= 1'b0;
                        // halt wins over a simultaneous jump and leaves pc untouched
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            if (pc_src) begin
                                pc <= AW'(ir[12:0]);
                            end
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
